// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 scan-code-set-2 receiver and ASCII translator.
// Ports:
//   clk       in   system clock, all logic on posedge
//   reset     in   synchronous active-high reset
//   ps2_clk   in   raw keyboard clock pin (asynchronous)
//   ps2_data  in   raw keyboard data pin (asynchronous)
//   key_out   out  [7:0] ASCII of last translated key, held between strobes
//   p_valid   out  one-cycle strobe, key_out carries a new character
//   shift     out  left or right shift held
//   caps      out  caps-lock toggle state
//   err       out  one-cycle pulse on parity/start/stop/timeout error
module ps2_keyboard #(
   parameter int TIMEOUT_CYCLES = 2000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key_out,
   output logic       p_valid,
   output logic       shift,
   output logic       caps,
   output logic       err
);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
   // pc: [0],[1] synchronizer, [2] previous synchronized value for edge detect
   logic [2:0]    pc_q, pc_d;
   logic [1:0]    pd_q, pd_d;
   logic [9:0]    sr_q, sr_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [WW-1:0] wd_q, wd_d;
   logic [7:0]    scan_q, scan_d, key_q, key_d;
   logic          scan_valid_q, scan_valid_d, err_q, err_d, p_valid_q, p_valid_d;
   logic          lshift_q, lshift_d, rshift_q, rshift_d, caps_q, caps_d, held_q, held_d;
   state_t        state_q, state_d;
   logic          fall, last, timeout, frame_ok, ext, is_make, is_brk;
   logic [10:0]   frame;
   logic [8:0]    xl;
   // Returns {hit, ascii}; shift/caps are the state before this make.
   function automatic logic [8:0] xlate(input logic [7:0] c, input logic e, input logic sh, input logic cp);
      logic [7:0]  l;
      logic [15:0] d;
      l = 8'h00;
      d = 16'h0000;
      case (c)
         8'h1C: l = "a"; 8'h32: l = "b"; 8'h21: l = "c"; 8'h23: l = "d";
         8'h24: l = "e"; 8'h2B: l = "f"; 8'h34: l = "g"; 8'h33: l = "h";
         8'h43: l = "i"; 8'h3B: l = "j"; 8'h42: l = "k"; 8'h4B: l = "l";
         8'h3A: l = "m"; 8'h31: l = "n"; 8'h44: l = "o"; 8'h4D: l = "p";
         8'h15: l = "q"; 8'h2D: l = "r"; 8'h1B: l = "s"; 8'h2C: l = "t";
         8'h3C: l = "u"; 8'h2A: l = "v"; 8'h1D: l = "w"; 8'h22: l = "x";
         8'h35: l = "y"; 8'h1A: l = "z";
         default: l = 8'h00;
      endcase
      case (c)
         8'h16: d = {"1", "!"}; 8'h1E: d = {"2", "@"}; 8'h26: d = {"3", "#"};
         8'h25: d = {"4", "$"}; 8'h2E: d = {"5", "%"}; 8'h36: d = {"6", "^"};
         8'h3D: d = {"7", "&"}; 8'h3E: d = {"8", "*"}; 8'h46: d = {"9", "("};
         8'h45: d = {"0", ")"};
         default: d = 16'h0000;
      endcase
      if (e) return (c == 8'h5A) ? 9'h10A : 9'h000;
      if (l != 8'h00) return {1'b1, (sh ^ cp) ? l - 8'h20 : l};
      if (d != 16'h0000) return {1'b1, sh ? d[7:0] : d[15:8]};
      return (c == 8'h29) ? 9'h120 : (c == 8'h5A) ? 9'h10A : (c == 8'h66) ? 9'h108 : 9'h000;
   endfunction
   assign fall     = pc_q[2] & ~pc_q[1];
   assign frame    = {pd_q[1], sr_q};
   assign last     = fall && cnt_q == 4'd10;
   assign frame_ok = ~frame[0] & frame[10] & ^frame[9:1];
   // An edge in the same cycle as the timeout wins: the frame is still alive.
   assign timeout  = ~fall && cnt_q != 4'd0 && wd_q == WW'(TIMEOUT_CYCLES);
   assign ext      = state_q == EXT || state_q == EXT_BRK;
   assign is_brk   = scan_valid_q && (state_q == BRK || state_q == EXT_BRK);
   assign is_make  = scan_valid_q && ((state_q == IDLE && scan_q != 8'hE0 && scan_q != 8'hF0) ||
                                      (state_q == EXT && scan_q != 8'hF0));
   assign xl       = xlate(scan_q, ext, lshift_q | rshift_q, caps_q);
   always_comb begin
      pc_d         = {pc_q[1:0], ps2_clk};
      pd_d         = {pd_q[0], ps2_data};
      sr_d         = fall ? frame[10:1] : sr_q;
      cnt_d        = (last || timeout) ? 4'd0 : fall ? cnt_q + 4'd1 : cnt_q;
      wd_d         = (fall || cnt_q == 4'd0) ? '0 : wd_q + 1'b1;
      scan_valid_d = last & frame_ok;
      scan_d       = (last & frame_ok) ? frame[8:1] : scan_q;
      err_d        = (last & ~frame_ok) | timeout;
      state_d      = !scan_valid_q ? state_q :
                     state_q == IDLE ? (scan_q == 8'hE0 ? EXT : scan_q == 8'hF0 ? BRK : IDLE) :
                     state_q == EXT ? (scan_q == 8'hF0 ? EXT_BRK : IDLE) : IDLE;
      lshift_d     = (scan_q == 8'h12 && (is_make || is_brk)) ? is_make : lshift_q;
      rshift_d     = (scan_q == 8'h59 && (is_make || is_brk)) ? is_make : rshift_q;
      // caps_held blocks typematic repeats of caps-lock from re-toggling
      held_d       = (scan_q == 8'h58 && (is_make || is_brk)) ? is_make : held_q;
      caps_d       = caps_q ^ (is_make && scan_q == 8'h58 && !held_q);
      p_valid_d    = is_make & xl[8];
      key_d        = p_valid_d ? xl[7:0] : key_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= 3'b111;
         pd_q         <= 2'b11;
         sr_q         <= '0;
         cnt_q        <= '0;
         wd_q         <= '0;
         scan_q       <= '0;
         scan_valid_q <= 1'b0;
         err_q        <= 1'b0;
         state_q      <= IDLE;
         lshift_q     <= 1'b0;
         rshift_q     <= 1'b0;
         held_q       <= 1'b0;
         caps_q       <= 1'b0;
         p_valid_q    <= 1'b0;
         key_q        <= '0;
      end else begin
         pc_q         <= pc_d;
         pd_q         <= pd_d;
         sr_q         <= sr_d;
         cnt_q        <= cnt_d;
         wd_q         <= wd_d;
         scan_q       <= scan_d;
         scan_valid_q <= scan_valid_d;
         err_q        <= err_d;
         state_q      <= state_d;
         lshift_q     <= lshift_d;
         rshift_q     <= rshift_d;
         held_q       <= held_d;
         caps_q       <= caps_d;
         p_valid_q    <= p_valid_d;
         key_q        <= key_d;
      end
   end
   assign key_out = key_q;
   assign p_valid = p_valid_q;
   assign shift   = lshift_q | rshift_q;
   assign caps    = caps_q;
   assign err     = err_q;
endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed table-driven bench for ps2_keyboard.
module tb_ps2_keyboard;
   localparam int TO = 2000;
   localparam int H  = 10;
   logic       clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic [7:0] key_out;
   logic       p_valid, shift, caps, err;
   int         tests = 0, fails = 0, nerr = 0;
   logic [7:0] got[$];
   logic       pv_prev = 1'b0;
   typedef struct packed {
      int          n;
      logic [79:0] seq;
      logic [9:0]  flip;
      int          ns;
      logic [31:0] ex;
      int          ne;
      logic        sh;
      logic        cp;
   } vec_t;
   vec_t tbl[12];
   vec_t v;
   ps2_keyboard #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key_out(key_out), .p_valid(p_valid), .shift(shift), .caps(caps), .err(err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (p_valid) begin
         got.push_back(key_out);
         chk("p_valid single cycle", 32'(pv_prev), 32'd0);
      end
      if (err) nerr++;
      pv_prev <= p_valid;
   end
   function automatic logic [10:0] mk(input logic [7:0] c, input logic flip);
      return {1'b1, ~^c ^ flip, c, 1'b0};
   endfunction
   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) ps2_data = f[i];
         repeat (H) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (H) @(negedge clk);
         ps2_clk = 1'b1;
      end
   endtask
   task automatic send(input logic [7:0] c, input logic flip);
      send_bits(mk(c, flip), 11);
      repeat (3 * H) @(negedge clk);
   endtask
   initial begin
      tbl[0]  = '{3, 80'({8'h1C, 8'hF0, 8'h1C}), 10'd0, 1, 32'h61, 0, 1'b0, 1'b0};
      tbl[1]  = '{7, 80'({8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h16}), 10'd0, 2, 32'h4131, 0, 1'b0, 1'b0};
      tbl[2]  = '{9, 80'({8'h58, 8'h58, 8'hF0, 8'h58, 8'h1C, 8'h12, 8'h1C, 8'hF0, 8'h12}), 10'd0, 2, 32'h4161, 0, 1'b0, 1'b1};
      tbl[3]  = '{3, 80'({8'h58, 8'hF0, 8'h58}), 10'd0, 0, 32'h0, 0, 1'b0, 1'b0};
      tbl[4]  = '{8, 80'({8'h5A, 8'hE0, 8'h5A, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75}), 10'd0, 2, 32'h0A0A, 0, 1'b0, 1'b0};
      tbl[5]  = '{2, 80'({8'h1C, 8'h32}), 10'b10, 1, 32'h62, 1, 1'b0, 1'b0};
      tbl[6]  = '{3, 80'({8'hF0, 8'h1C, 8'h1C}), 10'b010, 0, 32'h0, 1, 1'b0, 1'b0};
      tbl[7]  = '{7, 80'({8'h12, 8'h36, 8'h45, 8'hF0, 8'h12, 8'h29, 8'h66}), 10'd0, 4, 32'h5E292008, 0, 1'b0, 1'b0};
      tbl[8]  = '{5, 80'({8'h2B, 8'h2B, 8'h2B, 8'hF0, 8'h2B}), 10'd0, 3, 32'h666666, 0, 1'b0, 1'b0};
      tbl[9]  = '{5, 80'({8'hF0, 8'h1C, 8'h76, 8'hE0, 8'h1C}), 10'd0, 0, 32'h0, 0, 1'b0, 1'b0};
      tbl[10] = '{8, 80'({8'h58, 8'hF0, 8'h58, 8'h16, 8'h1C, 8'h58, 8'hF0, 8'h58}), 10'd0, 2, 32'h3141, 0, 1'b0, 1'b0};
      tbl[11] = '{5, 80'({8'h59, 8'h1D, 8'hF0, 8'h59, 8'h1D}), 10'd0, 2, 32'h5777, 0, 1'b0, 1'b0};
      repeat (5) @(negedge clk);
      chk("reset key_out", 32'(key_out), 32'h0);
      chk("reset p_valid", 32'(p_valid), 32'h0);
      chk("reset shift", 32'(shift), 32'h0);
      chk("reset caps", 32'(caps), 32'h0);
      chk("reset err", 32'(err), 32'h0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      for (int k = 0; k < 12; k++) begin
         v = tbl[k];
         got.delete();
         nerr = 0;
         for (int i = 0; i < v.n; i++) send(v.seq[8*(v.n-1-i) +: 8], v.flip[v.n-1-i]);
         chk($sformatf("vec%0d strobes", k), 32'(got.size()), 32'(v.ns));
         for (int j = 0; j < v.ns; j++)
            chk($sformatf("vec%0d char%0d", k, j), (j < got.size()) ? 32'(got[j]) : 32'hFFFF_FFFF, 32'(v.ex[8*(v.ns-1-j) +: 8]));
         if (v.ns > 0) chk($sformatf("vec%0d key_out hold", k), 32'(key_out), 32'(v.ex[7:0]));
         chk($sformatf("vec%0d err count", k), 32'(nerr), 32'(v.ne));
         chk($sformatf("vec%0d shift", k), 32'(shift), 32'(v.sh));
         chk($sformatf("vec%0d caps", k), 32'(caps), 32'(v.cp));
      end
      send(8'h12, 1'b0);
      chk("shift after make", 32'(shift), 32'd1);
      send(8'h1C, 1'b0);
      send(8'hF0, 1'b0);
      send(8'h1C, 1'b0);
      chk("shift held across key", 32'(shift), 32'd1);
      send(8'hF0, 1'b0);
      send(8'h12, 1'b0);
      chk("shift after break", 32'(shift), 32'd0);
      got.delete();
      send_bits(mk(8'h29, 1'b0), 10);
      @(negedge clk) ps2_data = 1'b1;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      chk("latency no early strobe", 32'(p_valid), 32'd0);
      @(negedge clk);
      chk("latency strobe", 32'(p_valid), 32'd1);
      chk("latency key_out", 32'(key_out), 32'h20);
      @(negedge clk);
      chk("latency strobe ends", 32'(p_valid), 32'd0);
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (3 * H) @(negedge clk);
      nerr = 0;
      got.delete();
      send_bits(mk(8'h1C, 1'b0), 5);
      repeat (TO - 100) @(negedge clk);
      chk("no err before timeout", 32'(nerr), 32'd0);
      repeat (120) @(negedge clk);
      chk("timeout err", 32'(nerr), 32'd1);
      send(8'h29, 1'b0);
      chk("after timeout strobes", 32'(got.size()), 32'd1);
      chk("after timeout char", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF_FFFF, 32'h20);
      chk("after timeout err", 32'(nerr), 32'd1);
      send(8'h58, 1'b0);
      send(8'hF0, 1'b0);
      send(8'h58, 1'b0);
      send(8'h12, 1'b0);
      chk("pre-reset caps", 32'(caps), 32'd1);
      chk("pre-reset shift", 32'(shift), 32'd1);
      send_bits(mk(8'h1C, 1'b0), 4);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("mid reset caps", 32'(caps), 32'd0);
      chk("mid reset shift", 32'(shift), 32'd0);
      chk("mid reset key_out", 32'(key_out), 32'h0);
      nerr = 0;
      got.delete();
      repeat (3 * H) @(negedge clk);
      send(8'h1C, 1'b0);
      chk("post reset strobes", 32'(got.size()), 32'd1);
      chk("post reset char", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF_FFFF, 32'h61);
      chk("post reset err", 32'(nerr), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
